cache_miss_allocator: RTL and testbench
=======================================

Name: cache_miss_allocator

Overview:
- Miss-side controller that drives the per-set round-robin replacement policy. It owns the tag, valid and dirty arrays of a set-associative cache.
- On a miss it picks a way in this order: lowest invalid way first, otherwise the policy victim obtained with a one-cycle evict pulse.
- It writes back a dirty victim, fetches the line, fills it, and reports the allocated way.
- Sits between the cache hit/miss path and the memory controller. The data array is external and is written through the fill port.

Parameters:
- SETS, 4, number of sets (power of 2).
- WAYS, 4, ways per set (power of 2).
- ADDR_BITS, 8, line address width; addr = {tag, set}.
- DATA_BITS, 8, line width (one word per line).
- Derived (localparam): SET_BITS = $clog2(SETS), WAY_BITS = $clog2(WAYS), TAG_BITS = ADDR_BITS - SET_BITS.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- miss_valid  in  1  miss request.
- miss_ready  out  1  high only in IDLE.
- miss_addr  in  ADDR_BITS  missing line address.
- miss_write  in  1  line becomes dirty on fill.
- lk_addr  in  ADDR_BITS  combinational lookup address.
- lk_hit  out  1  valid way in the set has a matching tag.
- lk_way  out  WAY_BITS  lowest matching way; 0 if no hit.
- mark_dirty_valid  in  1  write-hit dirty update.
- mark_dirty_set  in  SET_BITS  set for the dirty update.
- mark_dirty_way  in  WAY_BITS  way for the dirty update.
- repl_set_idx  out  SET_BITS  set presented to the replacement policy.
- repl_evict_req  out  1  one-cycle evict pulse.
- repl_victim_way  in  WAY_BITS  combinational victim from the policy.
- wb_valid  out  1  writeback request.
- wb_ready  in  1  writeback accept.
- wb_addr  out  ADDR_BITS  {victim tag, set}.
- wb_way  out  WAY_BITS  way the data array reads for writeback.
- fetch_valid  out  1  fetch request.
- fetch_ready  in  1  fetch accept.
- fetch_addr  out  ADDR_BITS  address being fetched.
- fetch_resp_valid  in  1  fetch data returned.
- fetch_resp_data  in  DATA_BITS  returned line data.
- fill_valid  out  1  one-cycle data-array write.
- fill_set  out  SET_BITS  fill target set.
- fill_way  out  WAY_BITS  fill target way.
- fill_data  out  DATA_BITS  fill data.
- done_valid  out  1  one-cycle completion pulse.
- done_way  out  WAY_BITS  allocated way.

Behaviour:
- Reset:
  - State goes to IDLE; all valid and dirty bits clear; tags retained (don't-care).
  - All valid/pulse outputs are 0; registered address, way and data outputs are 0.
- FSM states: IDLE, PICK, WB, FETCH_REQ, FETCH_WAIT, FILL, DONE.
- IDLE:
  - Handshake is miss_valid & miss_ready.
  - Capture miss_addr and miss_write, then go to PICK.
- PICK (1 cycle), with repl_set_idx = captured set:
  - If any way in the set is invalid, choose the lowest invalid way. repl_evict_req stays 0.
  - Otherwise assert repl_evict_req for exactly this cycle and latch repl_victim_way in the same cycle (pre-increment value).
  - If the chosen way is valid and dirty, go to WB; otherwise go to FETCH_REQ.
- WB:
  - wb_valid is held with stable wb_addr and wb_way until wb_ready.
  - On acceptance, clear the victim's valid and dirty bits and go to FETCH_REQ.
- FETCH_REQ: fetch_valid is held with fetch_addr = captured addr until fetch_ready, then go to FETCH_WAIT.
- FETCH_WAIT:
  - Wait for fetch_resp_valid and register the data.
  - fetch_resp_valid in any other state is ignored.
- FILL (1 cycle):
  - fill_valid = 1.
  - Write the tag, set valid = 1, set dirty = captured miss_write.
- DONE: done_valid = 1 with done_way for one cycle, then return to IDLE.
- Minimum latency (clean victim, ready and response immediate): miss accepted at cycle N; done_valid at cycle N+5.
- Lookup (lk_*):
  - Purely combinational from the arrays.
  - Reflects the FILL update from the next cycle onward.
- mark_dirty:
  - Applies any cycle the target entry is valid; ignored if the entry is invalid.
  - If it targets the same entry as a FILL in the same cycle, FILL wins.
  - If it targets a victim being accepted in WB in the same cycle, the clear wins.
- Victim selection happens once per miss. Pointers advance only on full sets.
- reset asserted in any state aborts the operation; no partial fill is committed.

Optional Feature:
- ALLOC_STATS_EN defined:
  - Adds outputs stat_evictions[15:0] and stat_writebacks[15:0].
  - Both are saturating counters that clear on reset.
  - stat_evictions increments each PICK cycle with repl_evict_req; stat_writebacks increments on each WB acceptance.
- ALLOC_STATS_EN undefined: no ports and no counter logic.

Decomposition:
- Package cache_pkg holds:
  - the alloc_state_t enum;
  - helper functions addr_set() and addr_tag();
  - the shared SET/WAY width localparams.
- One sub-module, cache_tag_store: the tag, valid and dirty arrays, lookup compare, invalid-way priority encoder, and the write ports for fill, mark_dirty and clear.

Test Plan:
- Empty cache, miss addr 0x12 (SETS=4, so set 2) -> no evict pulse, done_way=0, lk_hit for 0x12 the next cycle.
- Fill ways 0-3 of set 1 with clean lines, then miss 0x45 -> evict pulse in PICK, done_way=0; a second miss 0x85 -> done_way=1.
- Set 1 full with way 0 dirty (miss_write=1), then miss 0xC1 -> wb_addr = that way's {tag,set} held until wb_ready asserted after 3 stall cycles, then the fetch proceeds.
- Hold fetch_ready low 4 cycles and resp 6 cycles -> fetch_addr stable throughout, miss_ready low throughout, exactly one fill_valid.
- Assert reset during FETCH_WAIT -> FSM returns to IDLE, all valid bits 0, no fill_valid, and no done_valid after release.
- mark_dirty on the way being filled, in the FILL cycle, with miss_write=0 -> dirty stays 0 and no writeback on the later eviction.

Source files
------------

// File: rtl/cache_miss_allocator_pkg.sv
// Shared types and helpers for the cache miss allocator.
// Holds the allocator state encoding, default geometry and the
// address split helpers used by the hit/miss path.
package cache_pkg;

  localparam int CACHE_SETS      = 4;
  localparam int CACHE_WAYS      = 4;
  localparam int CACHE_ADDR_BITS = 8;
  localparam int CACHE_DATA_BITS = 8;
  localparam int CACHE_SET_BITS  = $clog2(CACHE_SETS);
  localparam int CACHE_WAY_BITS  = $clog2(CACHE_WAYS);
  localparam int CACHE_TAG_BITS  = CACHE_ADDR_BITS - CACHE_SET_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_WB,
    ST_FETCH_REQ,
    ST_FETCH_WAIT,
    ST_FILL,
    ST_DONE
  } alloc_state_t;

  // Line address is {tag, set}; set sits in the low bits.
  function automatic logic [CACHE_SET_BITS-1:0] addr_set(input logic [CACHE_ADDR_BITS-1:0] addr);
    return addr[CACHE_SET_BITS-1:0];
  endfunction

  function automatic logic [CACHE_TAG_BITS-1:0] addr_tag(input logic [CACHE_ADDR_BITS-1:0] addr);
    return addr[CACHE_ADDR_BITS-1:CACHE_SET_BITS];
  endfunction

endpackage

// File: rtl/cache_miss_allocator_if.sv
// Bus bundle between the allocator, the hit/miss path, the replacement
// policy and the memory controller. slave = allocator view, master =
// environment view.
interface cache_miss_allocator_if #(
  parameter int ADDR_BITS = cache_pkg::CACHE_ADDR_BITS,
  parameter int DATA_BITS = cache_pkg::CACHE_DATA_BITS,
  parameter int SET_BITS  = cache_pkg::CACHE_SET_BITS,
  parameter int WAY_BITS  = cache_pkg::CACHE_WAY_BITS
);
  logic                 miss_valid;
  logic                 miss_ready;
  logic [ADDR_BITS-1:0] miss_addr;
  logic                 miss_write;
  logic [ADDR_BITS-1:0] lk_addr;
  logic                 lk_hit;
  logic [WAY_BITS-1:0]  lk_way;
  logic                 mark_dirty_valid;
  logic [SET_BITS-1:0]  mark_dirty_set;
  logic [WAY_BITS-1:0]  mark_dirty_way;
  logic [SET_BITS-1:0]  repl_set_idx;
  logic                 repl_evict_req;
  logic [WAY_BITS-1:0]  repl_victim_way;
  logic                 wb_valid;
  logic                 wb_ready;
  logic [ADDR_BITS-1:0] wb_addr;
  logic [WAY_BITS-1:0]  wb_way;
  logic                 fetch_valid;
  logic                 fetch_ready;
  logic [ADDR_BITS-1:0] fetch_addr;
  logic                 fetch_resp_valid;
  logic [DATA_BITS-1:0] fetch_resp_data;
  logic                 fill_valid;
  logic [SET_BITS-1:0]  fill_set;
  logic [WAY_BITS-1:0]  fill_way;
  logic [DATA_BITS-1:0] fill_data;
  logic                 done_valid;
  logic [WAY_BITS-1:0]  done_way;

  modport slave (
    input  miss_valid, miss_addr, miss_write, lk_addr,
           mark_dirty_valid, mark_dirty_set, mark_dirty_way,
           repl_victim_way, wb_ready, fetch_ready,
           fetch_resp_valid, fetch_resp_data,
    output miss_ready, lk_hit, lk_way, repl_set_idx, repl_evict_req,
           wb_valid, wb_addr, wb_way, fetch_valid, fetch_addr,
           fill_valid, fill_set, fill_way, fill_data, done_valid, done_way
  );

  modport master (
    output miss_valid, miss_addr, miss_write, lk_addr,
           mark_dirty_valid, mark_dirty_set, mark_dirty_way,
           repl_victim_way, wb_ready, fetch_ready,
           fetch_resp_valid, fetch_resp_data,
    input  miss_ready, lk_hit, lk_way, repl_set_idx, repl_evict_req,
           wb_valid, wb_addr, wb_way, fetch_valid, fetch_addr,
           fill_valid, fill_set, fill_way, fill_data, done_valid, done_way
  );
endinterface

// File: rtl/cache_miss_allocator_tag_store.sv
// Tag, valid and dirty arrays for the set-associative cache.
// Provides the combinational lookup, the lowest-invalid-way encoder for
// the set being allocated, and the fill / mark-dirty / clear write ports.
// Dirty priority within a cycle: fill over clear over mark-dirty.
module cache_tag_store
  import cache_pkg::*;
#(
  parameter  int SETS     = CACHE_SETS,
  parameter  int WAYS     = CACHE_WAYS,
  parameter  int TAG_BITS = CACHE_TAG_BITS,
  localparam int SET_BITS = $clog2(SETS),
  localparam int WAY_BITS = $clog2(WAYS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SET_BITS-1:0] lk_set,
  input  logic [TAG_BITS-1:0] lk_tag,
  output logic                lk_hit,
  output logic [WAY_BITS-1:0] lk_way,
  input  logic [SET_BITS-1:0] q_set,
  output logic                inv_any,
  output logic [WAY_BITS-1:0] inv_way,
  input  logic [WAY_BITS-1:0] rd_way,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_BITS-1:0] rd_tag,
  input  logic                fill_en,
  input  logic [SET_BITS-1:0] fill_set,
  input  logic [WAY_BITS-1:0] fill_way,
  input  logic [TAG_BITS-1:0] fill_tag,
  input  logic                fill_dirty,
  input  logic                md_en,
  input  logic [SET_BITS-1:0] md_set,
  input  logic [WAY_BITS-1:0] md_way,
  input  logic                clr_en,
  input  logic [SET_BITS-1:0] clr_set,
  input  logic [WAY_BITS-1:0] clr_way
);

  logic [SETS-1:0][WAYS-1:0]               valid_q, valid_d;
  logic [SETS-1:0][WAYS-1:0]               dirty_q, dirty_d;
  logic [SETS-1:0][WAYS-1:0][TAG_BITS-1:0] tag_q, tag_d;

  // Lookup: lowest valid way whose tag matches.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag)) begin
        lk_hit = 1'b1;
        lk_way = WAY_BITS'(w);
      end
    end
  end

  // Lowest invalid way of the queried set.
  always_comb begin
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[q_set][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_BITS'(w);
      end
    end
  end

  assign rd_valid = valid_q[q_set][rd_way];
  assign rd_dirty = dirty_q[q_set][rd_way];
  assign rd_tag   = tag_q[q_set][rd_way];

  // Array updates; later statements take priority.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    if (md_en && valid_q[md_set][md_way]) begin
      dirty_d[md_set][md_way] = 1'b1;
    end
    if (clr_en) begin
      valid_d[clr_set][clr_way] = 1'b0;
      dirty_d[clr_set][clr_way] = 1'b0;
    end
    if (fill_en) begin
      valid_d[fill_set][fill_way] = 1'b1;
      dirty_d[fill_set][fill_way] = fill_dirty;
      tag_d[fill_set][fill_way]   = fill_tag;
    end
  end

  // Valid/dirty clear on reset; a fill in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tags are don't-care while invalid, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

endmodule

// File: rtl/cache_miss_allocator.sv
// Miss-side allocator: picks a way (lowest invalid, else the policy
// victim), writes back a dirty victim, fetches and fills the line, and
// reports the allocated way.
// Optional counters: define ALLOC_STATS_EN to add stat_evictions and
// stat_writebacks.
//
// state      | meaning
// IDLE       | ready for a miss
// PICK       | choose way; evict pulse when the set is full
// WB         | dirty victim writeback pending
// FETCH_REQ  | fetch request pending
// FETCH_WAIT | waiting for fetch data
// FILL       | write data array and tag/valid/dirty
// DONE       | report allocated way
module cache_miss_allocator
  import cache_pkg::*;
#(
  parameter int SETS      = CACHE_SETS,
  parameter int WAYS      = CACHE_WAYS,
  parameter int ADDR_BITS = CACHE_ADDR_BITS,
  parameter int DATA_BITS = CACHE_DATA_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  cache_miss_allocator_if.slave bus
`ifdef ALLOC_STATS_EN
  ,
  output logic [15:0]           stat_evictions,
  output logic [15:0]           stat_writebacks
`endif
);

  localparam int SET_BITS = $clog2(SETS);
  localparam int WAY_BITS = $clog2(WAYS);
  localparam int TAG_BITS = ADDR_BITS - SET_BITS;

  alloc_state_t         state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 write_q, write_d;
  logic [WAY_BITS-1:0]  way_q, way_d;
  logic                 miss_ready_q, miss_ready_d;
  logic [SET_BITS-1:0]  repl_set_idx_q, repl_set_idx_d;
  logic                 repl_evict_req_q, repl_evict_req_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [ADDR_BITS-1:0] wb_addr_q, wb_addr_d;
  logic [WAY_BITS-1:0]  wb_way_q, wb_way_d;
  logic                 fetch_valid_q, fetch_valid_d;
  logic [ADDR_BITS-1:0] fetch_addr_q, fetch_addr_d;
  logic                 fill_valid_q, fill_valid_d;
  logic [SET_BITS-1:0]  fill_set_q, fill_set_d;
  logic [WAY_BITS-1:0]  fill_way_q, fill_way_d;
  logic [DATA_BITS-1:0] fill_data_q, fill_data_d;
  logic                 done_valid_q, done_valid_d;
  logic [WAY_BITS-1:0]  done_way_q, done_way_d;

  logic [SET_BITS-1:0]  q_set;
  logic                 inv_any;
  logic [WAY_BITS-1:0]  inv_way;
  logic [WAY_BITS-1:0]  pick_way;
  logic                 rd_valid, rd_dirty;
  logic [TAG_BITS-1:0]  rd_tag;
  logic                 fill_en, clr_en;

  // In IDLE the encoder looks at the incoming set so the evict pulse can
  // be registered for the PICK cycle; afterwards it follows the capture.
  assign q_set    = (state_q == ST_IDLE) ? bus.miss_addr[SET_BITS-1:0] : addr_q[SET_BITS-1:0];
  assign pick_way = repl_evict_req_q ? bus.repl_victim_way : inv_way;
  assign fill_en  = (state_q == ST_FILL);
  assign clr_en   = (state_q == ST_WB) && bus.wb_ready;

  cache_tag_store #(
    .SETS     (SETS),
    .WAYS     (WAYS),
    .TAG_BITS (TAG_BITS)
  ) u_tag_store (
    .clk        (clk),
    .reset      (reset),
    .lk_set     (bus.lk_addr[SET_BITS-1:0]),
    .lk_tag     (bus.lk_addr[ADDR_BITS-1:SET_BITS]),
    .lk_hit     (bus.lk_hit),
    .lk_way     (bus.lk_way),
    .q_set      (q_set),
    .inv_any    (inv_any),
    .inv_way    (inv_way),
    .rd_way     (pick_way),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_tag     (rd_tag),
    .fill_en    (fill_en),
    .fill_set   (fill_set_q),
    .fill_way   (fill_way_q),
    .fill_tag   (addr_q[ADDR_BITS-1:SET_BITS]),
    .fill_dirty (write_q),
    .md_en      (bus.mark_dirty_valid),
    .md_set     (bus.mark_dirty_set),
    .md_way     (bus.mark_dirty_way),
    .clr_en     (clr_en),
    .clr_set    (addr_q[SET_BITS-1:0]),
    .clr_way    (way_q)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    write_d          = write_q;
    way_d            = way_q;
    repl_set_idx_d   = repl_set_idx_q;
    repl_evict_req_d = 1'b0;
    wb_addr_d        = wb_addr_q;
    wb_way_d         = wb_way_q;
    fetch_addr_d     = fetch_addr_q;
    fill_set_d       = fill_set_q;
    fill_way_d       = fill_way_q;
    fill_data_d      = fill_data_q;
    done_way_d       = done_way_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.miss_valid) begin
          state_d          = ST_PICK;
          addr_d           = bus.miss_addr;
          write_d          = bus.miss_write;
          repl_set_idx_d   = q_set;
          repl_evict_req_d = !inv_any;
          fetch_addr_d     = bus.miss_addr;
        end
      end
      ST_PICK: begin
        way_d     = pick_way;
        wb_way_d  = pick_way;
        wb_addr_d = {rd_tag, addr_q[SET_BITS-1:0]};
        state_d   = (rd_valid && rd_dirty) ? ST_WB : ST_FETCH_REQ;
      end
      ST_WB: begin
        if (bus.wb_ready) state_d = ST_FETCH_REQ;
      end
      ST_FETCH_REQ: begin
        if (bus.fetch_ready) state_d = ST_FETCH_WAIT;
      end
      ST_FETCH_WAIT: begin
        if (bus.fetch_resp_valid) begin
          state_d     = ST_FILL;
          fill_data_d = bus.fetch_resp_data;
          fill_set_d  = addr_q[SET_BITS-1:0];
          fill_way_d  = way_q;
        end
      end
      ST_FILL: begin
        state_d    = ST_DONE;
        done_way_d = way_q;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    miss_ready_d  = (state_d == ST_IDLE);
    wb_valid_d    = (state_d == ST_WB);
    fetch_valid_d = (state_d == ST_FETCH_REQ);
    fill_valid_d  = (state_d == ST_FILL);
    done_valid_d  = (state_d == ST_DONE);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      addr_q           <= '0;
      write_q          <= 1'b0;
      way_q            <= '0;
      miss_ready_q     <= 1'b1;
      repl_set_idx_q   <= '0;
      repl_evict_req_q <= 1'b0;
      wb_valid_q       <= 1'b0;
      wb_addr_q        <= '0;
      wb_way_q         <= '0;
      fetch_valid_q    <= 1'b0;
      fetch_addr_q     <= '0;
      fill_valid_q     <= 1'b0;
      fill_set_q       <= '0;
      fill_way_q       <= '0;
      fill_data_q      <= '0;
      done_valid_q     <= 1'b0;
      done_way_q       <= '0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      write_q          <= write_d;
      way_q            <= way_d;
      miss_ready_q     <= miss_ready_d;
      repl_set_idx_q   <= repl_set_idx_d;
      repl_evict_req_q <= repl_evict_req_d;
      wb_valid_q       <= wb_valid_d;
      wb_addr_q        <= wb_addr_d;
      wb_way_q         <= wb_way_d;
      fetch_valid_q    <= fetch_valid_d;
      fetch_addr_q     <= fetch_addr_d;
      fill_valid_q     <= fill_valid_d;
      fill_set_q       <= fill_set_d;
      fill_way_q       <= fill_way_d;
      fill_data_q      <= fill_data_d;
      done_valid_q     <= done_valid_d;
      done_way_q       <= done_way_d;
    end
  end

  assign bus.miss_ready     = miss_ready_q;
  assign bus.repl_set_idx   = repl_set_idx_q;
  assign bus.repl_evict_req = repl_evict_req_q;
  assign bus.wb_valid       = wb_valid_q;
  assign bus.wb_addr        = wb_addr_q;
  assign bus.wb_way         = wb_way_q;
  assign bus.fetch_valid    = fetch_valid_q;
  assign bus.fetch_addr     = fetch_addr_q;
  assign bus.fill_valid     = fill_valid_q;
  assign bus.fill_set       = fill_set_q;
  assign bus.fill_way       = fill_way_q;
  assign bus.fill_data      = fill_data_q;
  assign bus.done_valid     = done_valid_q;
  assign bus.done_way       = done_way_q;

`ifdef ALLOC_STATS_EN
  logic [15:0] stat_ev_q, stat_ev_d;
  logic [15:0] stat_wb_q, stat_wb_d;

  // Saturating event counters.
  always_comb begin
    stat_ev_d = stat_ev_q;
    stat_wb_d = stat_wb_q;
    if ((state_q == ST_PICK) && repl_evict_req_q && (stat_ev_q != 16'hFFFF)) stat_ev_d = stat_ev_q + 16'd1;
    if (clr_en && (stat_wb_q != 16'hFFFF)) stat_wb_d = stat_wb_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ev_q <= '0;
      stat_wb_q <= '0;
    end else begin
      stat_ev_q <= stat_ev_d;
      stat_wb_q <= stat_wb_d;
    end
  end

  assign stat_evictions  = stat_ev_q;
  assign stat_writebacks = stat_wb_q;
`endif

endmodule

// File: tb/tb_cache_miss_allocator.sv
// Directed bench for cache_miss_allocator: a miss vector table plus
// hand-written sequences for writeback stall, fetch stall, fill/mark-dirty
// collision and reset during fetch. A round-robin policy model supplies
// victims; memory returns addr ^ 0xA5.
module tb_cache_miss_allocator;
  import cache_pkg::*;

  localparam int SETS = 4, WAYS = 4, ADDR_BITS = 8, DATA_BITS = 8;
  localparam int SET_BITS = 2, WAY_BITS = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_miss_allocator_if #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
                            .SET_BITS(SET_BITS), .WAY_BITS(WAY_BITS)) bus ();

`ifdef ALLOC_STATS_EN
  logic [15:0] stat_evictions, stat_writebacks;
`endif

  cache_miss_allocator #(.SETS(SETS), .WAYS(WAYS), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ALLOC_STATS_EN
    ,
    .stat_evictions  (stat_evictions),
    .stat_writebacks (stat_writebacks)
`endif
  );

  // Round-robin replacement policy model.
  logic [WAY_BITS-1:0] rr_ptr [SETS];
  assign bus.repl_victim_way = rr_ptr[bus.repl_set_idx];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SETS; i++) rr_ptr[i] <= '0;
    end else if (bus.repl_evict_req) begin
      rr_ptr[bus.repl_set_idx] <= rr_ptr[bus.repl_set_idx] + 1'b1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_data(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  // Per-miss observations.
  int          r_evicts, r_wbs, r_wb_cycles, r_fills, r_lat;
  logic        r_done, r_wb_stable, r_fetch_stable, r_ready_low;
  logic [7:0]  r_wb_addr, r_fill_data;
  logic [1:0]  r_wb_way, r_fill_set, r_fill_way, r_done_way;

  task automatic run_miss(input logic [7:0] addr, input logic write, input int wb_stall,
                          input int fetch_stall, input int resp_stall, input logic junk_resp,
                          input logic md_on_fill);
    int   wb_seen, fetch_seen, wait_cnt;
    logic waiting;
    @(negedge clk);
    check($sformatf("idle_ready_%02h", addr), 32'(bus.miss_ready), 32'd1);
    check($sformatf("idle_done_%02h", addr), 32'(bus.done_valid), 32'd0);
    bus.miss_valid = 1'b1;
    bus.miss_addr  = addr;
    bus.miss_write = write;
    r_evicts = 0; r_wbs = 0; r_wb_cycles = 0; r_fills = 0; r_lat = 0;
    r_done = 1'b0; r_wb_stable = 1'b1; r_fetch_stable = 1'b1; r_ready_low = 1'b1;
    r_wb_addr = '0; r_wb_way = '0; r_fill_data = '0; r_fill_set = '0; r_fill_way = '0; r_done_way = '0;
    wb_seen = 0; fetch_seen = 0; wait_cnt = 0; waiting = 1'b0;
    for (int k = 1; k <= 100 && !r_done; k++) begin
      @(negedge clk);
      bus.miss_valid       = 1'b0;
      bus.wb_ready         = 1'b0;
      bus.fetch_ready      = 1'b0;
      bus.fetch_resp_valid = 1'b0;
      bus.mark_dirty_valid = 1'b0;
      if (bus.miss_ready) r_ready_low = 1'b0;
      if (bus.repl_evict_req) r_evicts++;
      if (bus.wb_valid) begin
        wb_seen++;
        r_wb_cycles++;
        if (wb_seen == 1) begin
          r_wb_addr = bus.wb_addr;
          r_wb_way  = bus.wb_way;
        end else if (bus.wb_addr !== r_wb_addr || bus.wb_way !== r_wb_way) begin
          r_wb_stable = 1'b0;
        end
        if (wb_seen == wb_stall + 1) begin
          bus.wb_ready = 1'b1;
          r_wbs++;
        end else if (junk_resp) begin
          bus.fetch_resp_valid = 1'b1;
          bus.fetch_resp_data  = 8'hEE;
        end
      end
      if (waiting) begin
        wait_cnt++;
        if (wait_cnt == resp_stall + 1) begin
          bus.fetch_resp_valid = 1'b1;
          bus.fetch_resp_data  = mem_data(addr);
          waiting = 1'b0;
        end
      end
      if (bus.fetch_valid) begin
        fetch_seen++;
        if (bus.fetch_addr !== addr) r_fetch_stable = 1'b0;
        if (fetch_seen == fetch_stall + 1) begin
          bus.fetch_ready = 1'b1;
          waiting = 1'b1;
        end
      end
      if (bus.fill_valid) begin
        r_fills++;
        r_fill_set  = bus.fill_set;
        r_fill_way  = bus.fill_way;
        r_fill_data = bus.fill_data;
        if (md_on_fill) begin
          bus.mark_dirty_valid = 1'b1;
          bus.mark_dirty_set   = bus.fill_set;
          bus.mark_dirty_way   = bus.fill_way;
        end
      end
      if (bus.done_valid) begin
        r_done     = 1'b1;
        r_done_way = bus.done_way;
        r_lat      = k;
      end
    end
    check($sformatf("done_seen_%02h", addr), 32'(r_done), 32'd1);
  endtask

  task automatic lookup(input logic [7:0] a, input logic exp_hit, input logic [1:0] exp_way);
    @(negedge clk);
    bus.lk_addr = a;
    #1;
    check($sformatf("lk_hit_%02h", a), 32'(bus.lk_hit), 32'(exp_hit));
    check($sformatf("lk_way_%02h", a), 32'(bus.lk_way), 32'(exp_way));
  endtask

  typedef struct {
    logic [7:0] addr;
    logic       write;
    int         exp_evict;
    logic [1:0] exp_way;
    int         exp_wb;
    logic [7:0] exp_wb_addr;
  } miss_vec_t;

  typedef struct {
    logic [7:0] addr;
    logic       exp_hit;
    logic [1:0] exp_way;
  } lk_vec_t;

  miss_vec_t mv[16];
  lk_vec_t   lv[9];

  task automatic apply_vec(input int i);
    run_miss(mv[i].addr, mv[i].write, 0, 0, 0, 1'b0, 1'b0);
    check($sformatf("v%0d_evict", i), 32'(r_evicts), 32'(mv[i].exp_evict));
    check($sformatf("v%0d_way", i), 32'(r_done_way), 32'(mv[i].exp_way));
    check($sformatf("v%0d_wbs", i), 32'(r_wbs), 32'(mv[i].exp_wb));
    if (mv[i].exp_wb != 0) check($sformatf("v%0d_wb_addr", i), 32'(r_wb_addr), 32'(mv[i].exp_wb_addr));
    check($sformatf("v%0d_lat", i), 32'(r_lat), 32'(5 + mv[i].exp_wb));
    check($sformatf("v%0d_fills", i), 32'(r_fills), 32'd1);
    check($sformatf("v%0d_fill_set", i), 32'(r_fill_set), 32'(addr_set(mv[i].addr)));
    check($sformatf("v%0d_fill_way", i), 32'(r_fill_way), 32'(mv[i].exp_way));
    check($sformatf("v%0d_fill_data", i), 32'(r_fill_data), 32'(mem_data(mv[i].addr)));
    check($sformatf("v%0d_ready_low", i), 32'(r_ready_low), 32'd1);
  endtask

  initial begin
    int seen, fills, dones;
    logic [7:0] cleared [4];

    mv[0]  = '{8'h01, 1'b0, 0, 2'd0, 0, 8'h00};
    mv[1]  = '{8'h05, 1'b0, 0, 2'd1, 0, 8'h00};
    mv[2]  = '{8'h09, 1'b0, 0, 2'd2, 0, 8'h00};
    mv[3]  = '{8'h0D, 1'b0, 0, 2'd3, 0, 8'h00};
    mv[4]  = '{8'h45, 1'b0, 1, 2'd0, 0, 8'h00};
    mv[5]  = '{8'h85, 1'b0, 1, 2'd1, 0, 8'h00};
    mv[6]  = '{8'h11, 1'b0, 1, 2'd2, 0, 8'h00};
    mv[7]  = '{8'h15, 1'b0, 1, 2'd3, 0, 8'h00};
    mv[8]  = '{8'h19, 1'b1, 1, 2'd0, 0, 8'h00};
    mv[9]  = '{8'h1D, 1'b0, 1, 2'd1, 0, 8'h00};
    mv[10] = '{8'h21, 1'b0, 1, 2'd2, 0, 8'h00};
    mv[11] = '{8'h25, 1'b0, 1, 2'd3, 0, 8'h00};
    mv[12] = '{8'h39, 1'b0, 1, 2'd3, 1, 8'h25};
    mv[13] = '{8'h3D, 1'b0, 1, 2'd0, 0, 8'h00};
    mv[14] = '{8'h41, 1'b0, 1, 2'd1, 0, 8'h00};
    mv[15] = '{8'h49, 1'b0, 1, 2'd2, 0, 8'h00};

    lv[0] = '{8'h19, 1'b1, 2'd0};
    lv[1] = '{8'h1D, 1'b1, 2'd1};
    lv[2] = '{8'h21, 1'b1, 2'd2};
    lv[3] = '{8'h25, 1'b1, 2'd3};
    lv[4] = '{8'h12, 1'b1, 2'd0};
    lv[5] = '{8'h45, 1'b0, 2'd0};
    lv[6] = '{8'h01, 1'b0, 2'd0};
    lv[7] = '{8'h16, 1'b0, 2'd0};
    lv[8] = '{8'h59, 1'b0, 2'd0};

    bus.miss_valid = 1'b0; bus.miss_addr = '0; bus.miss_write = 1'b0; bus.lk_addr = '0;
    bus.mark_dirty_valid = 1'b0; bus.mark_dirty_set = '0; bus.mark_dirty_way = '0;
    bus.wb_ready = 1'b0; bus.fetch_ready = 1'b0; bus.fetch_resp_valid = 1'b0; bus.fetch_resp_data = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_miss_ready", 32'(bus.miss_ready), 32'd1);
    check("rst_evict", 32'(bus.repl_evict_req), 32'd0);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    check("rst_fill_valid", 32'(bus.fill_valid), 32'd0);
    check("rst_done_valid", 32'(bus.done_valid), 32'd0);
    check("rst_wb_addr", 32'(bus.wb_addr), 32'd0);
    check("rst_fetch_addr", 32'(bus.fetch_addr), 32'd0);
    check("rst_fill_data", 32'(bus.fill_data), 32'd0);
    check("rst_done_way", 32'(bus.done_way), 32'd0);
    reset = 1'b0;
    lookup(8'h12, 1'b0, 2'd0);

    // Empty cache: lowest invalid way, no evict pulse.
    run_miss(8'h12, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    check("t1_evict", 32'(r_evicts), 32'd0);
    check("t1_way", 32'(r_done_way), 32'd0);
    check("t1_lat", 32'(r_lat), 32'd5);
    check("t1_fill_set", 32'(r_fill_set), 32'd2);
    lookup(8'h12, 1'b1, 2'd0);

    for (int i = 0; i < 12; i++) apply_vec(i);
    for (int i = 0; i < 9; i++) lookup(lv[i].addr, lv[i].exp_hit, lv[i].exp_way);

    // Dirty victim in way 0 with a 3-cycle writeback stall; stray fetch
    // responses during the stall must be ignored.
    run_miss(8'hC1, 1'b0, 3, 0, 0, 1'b1, 1'b0);
    check("wb_evict", 32'(r_evicts), 32'd1);
    check("wb_count", 32'(r_wbs), 32'd1);
    check("wb_addr", 32'(r_wb_addr), 32'h19);
    check("wb_way", 32'(r_wb_way), 32'd0);
    check("wb_cycles", 32'(r_wb_cycles), 32'd4);
    check("wb_stable", 32'(r_wb_stable), 32'd1);
    check("wb_done_way", 32'(r_done_way), 32'd0);
    check("wb_lat", 32'(r_lat), 32'd9);
    check("wb_fill_data", 32'(r_fill_data), 32'(mem_data(8'hC1)));
    lookup(8'h19, 1'b0, 2'd0);
    lookup(8'hC1, 1'b1, 2'd0);

    // Fetch accept stalled 4 cycles, response 6 cycles later.
    run_miss(8'h31, 1'b0, 0, 4, 6, 1'b0, 1'b0);
    check("st_way", 32'(r_done_way), 32'd1);
    check("st_fetch_stable", 32'(r_fetch_stable), 32'd1);
    check("st_ready_low", 32'(r_ready_low), 32'd1);
    check("st_fills", 32'(r_fills), 32'd1);
    check("st_lat", 32'(r_lat), 32'd15);
    check("st_wbs", 32'(r_wbs), 32'd0);

    // mark_dirty colliding with the fill of a clean line: fill wins.
    run_miss(8'h35, 1'b0, 0, 0, 0, 1'b0, 1'b1);
    check("md_way", 32'(r_done_way), 32'd2);

    // Write-hit dirty update on a valid entry (0x25 in set 1 way 3).
    @(negedge clk);
    bus.mark_dirty_valid = 1'b1;
    bus.mark_dirty_set   = 2'd1;
    bus.mark_dirty_way   = 2'd3;
    @(negedge clk);
    bus.mark_dirty_valid = 1'b0;

    for (int i = 12; i < 16; i++) apply_vec(i);

    // Reset while waiting on fetch data, with a response in the reset cycle.
    @(negedge clk);
    bus.miss_valid = 1'b1; bus.miss_addr = 8'h07; bus.miss_write = 1'b1;
    @(negedge clk);
    bus.miss_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      if (bus.fetch_valid) seen = 1;
      else @(negedge clk);
    end
    check("rf_fetch_seen", 32'(seen), 32'd1);
    bus.fetch_ready = 1'b1;
    @(negedge clk);
    bus.fetch_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bus.fetch_resp_valid = 1'b1;
    bus.fetch_resp_data  = mem_data(8'h07);
    @(negedge clk);
    check("rf_no_fill_rst", 32'(bus.fill_valid), 32'd0);
    bus.fetch_resp_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus.fetch_resp_valid = 1'b1;
    fills = 0; dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.fetch_resp_valid = 1'b0;
      if (bus.fill_valid) fills++;
      if (bus.done_valid) dones++;
    end
    check("rf_fills", 32'(fills), 32'd0);
    check("rf_dones", 32'(dones), 32'd0);
    check("rf_ready", 32'(bus.miss_ready), 32'd1);
    cleared[0] = 8'h12; cleared[1] = 8'hC1; cleared[2] = 8'h49; cleared[3] = 8'h39;
    for (int i = 0; i < 4; i++) lookup(cleared[i], 1'b0, 2'd0);

    // Allocator is usable again after the abort.
    run_miss(8'h12, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    check("post_evict", 32'(r_evicts), 32'd0);
    check("post_way", 32'(r_done_way), 32'd0);
    check("post_lat", 32'(r_lat), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
